mux_scan_n_1: RTL and testbench
===============================

Name: mux_scan_n_1

Overview:
- Parametrised N-input, W-bit-wide registered multiplexer with two modes.
- Manual mode: a host-loaded select register chooses the channel.
- Scan mode: a dwell counter auto-steps through the channels.
- Sits between multi-channel sources (sensors, status buses) and a single shared consumer such as a display or logger that needs time-division access.

Parameters:
- N, 8, number of input channels (2..64).
- W, 4, bits per channel.
- DWELL, 4, clock cycles spent on each channel in scan mode (1..255).
- SW, $clog2(N), select/channel index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- I  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- S  input  SW  channel index for load.
- load  input  1  strobe: capture S into the select register.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  clock enable; 0 freezes all state.
- Y  output  W  registered selected data.
- ch  output  SW  channel currently driving Y.
- valid  output  1  Y holds real data.
- wrap  output  1  one-cycle pulse when the scan passes channel N-1 -> 0.
- err  output  1  one-cycle pulse on load with S >= N.

Behaviour:
- Reset (rst_n low, asynchronous): sel=0, dwell counter=0, Y=0, ch=0, valid=0, wrap=0, err=0, mode_q=0.
- All state updates below occur only on rising clk with en=1. With en=0, every register holds and wrap/err are forced to 0.
- Datapath: Y <= I[sel], ch <= sel, both updated every enabled cycle.
  - Latency: 1 cycle from sel change to Y/ch.
  - I is sampled live, not latched at select time.
- valid: set on the first enabled edge after reset release and stays 1 until the next reset.
- load priority (either mode):
  - load=1 with S<N: sel <= S, dwell counter <= 0.
  - load=1 with S>=N (only possible when N is not a power of two): sel unchanged, err=1 for one cycle.
  - load overrides any scan advance in the same cycle.
- Manual mode (mode=0): sel changes only via load; the dwell counter holds at 0.
- Scan mode (mode=1), FSM per channel:
  - Counter counts 0..DWELL-1.
  - On count=DWELL-1: counter <= 0 and sel <= (sel==N-1) ? 0 : sel+1.
  - When sel wraps N-1 -> 0: wrap=1 for that cycle, coincident with the registered advance.
  - DWELL=1: sel advances every enabled cycle.
- Mode change: mode is registered into mode_q. When mode != mode_q, the dwell counter clears to 0 and sel holds that cycle. Scan resumes from the current sel; the full dwell applies after the switch.
- Simultaneous load and mode change: load value taken, counter cleared.
- Reset mid-scan: immediate return to reset values. Scanning restarts at channel 0 once rst_n rises, if mode=1.
- Arithmetic: the counter is $clog2(DWELL+1) bits wide, with no overflow beyond DWELL-1. sel increments modulo N, not modulo 2^SW.

Optional Feature:
- Macro: MUX_SCAN_SKIP_EN.
- Defined:
  - Adds input port skip [N-1:0] (1 = exclude channel).
  - In scan mode, an advance moves sel to the next unmasked channel above sel, wrapping circularly. wrap pulses whenever that search passes index N-1.
  - If every channel is masked, sel holds and wrap stays 0.
  - If the current sel is masked (by load or a mask change), it is still dwelled upon for the remainder of its dwell and then left.
  - Manual load ignores skip.
- Not defined: no skip port; all N channels are visited in order.

Test Plan:
- Reset, N=8, W=4, I=32'h76543210, mode=0, en=1: Y=0, ch=0, valid=0 during reset; valid=1 and Y=4'h0 one edge after release.
- Manual load S=5: ch=5 and Y=4'h5 one cycle after the load edge; change I[23:20] to 4'hA and Y follows to 4'hA next cycle.
- Scan, DWELL=4, from ch=0: ch steps 0,1,...,7 every 4 cycles; wrap pulses once at the 7->0 step; exactly 32 cycles per full cycle of channels.
- Load S=3 mid-dwell in scan mode, plus en=0 for 5 cycles: sel jumps to 3 with a full 4-cycle dwell; during en=0, Y/ch/counter are frozen and wrap=0.
- N=6, load S=7: err pulses 1 cycle and ch unchanged; scan from 5 wraps to 0 (never 6 or 7).
- MUX_SCAN_SKIP_EN with skip=8'b0110_0110, DWELL=1: sequence 0,3,4,7,0 with wrap at 7->0; skip=8'hFF makes ch hold.

Source files
------------

// File: rtl/mux_scan_n_1.sv
// mux_scan_n_1: N-input, W-bit registered multiplexer.
// In manual mode the channel comes from a loaded select register.
// In scan mode a dwell counter steps through the channels automatically.
// Optional feature macro: MUX_SCAN_SKIP_EN adds a per-channel skip mask for scan mode.
module mux_scan_n_1 #(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int DWELL = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   I,
  input  logic [SW-1:0]    S,
  input  logic             load,
  input  logic             mode,
  input  logic             en,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [N-1:0]     skip,
`endif
  output logic [W-1:0]     Y,
  output logic [SW-1:0]    ch,
  output logic             valid,
  output logic             wrap,
  output logic             err
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);
  localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [SW-1:0] sel_q, sel_d, adv_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adv_wrap, wrap_d, err_d;
  logic [W-1:0]  chan [N];

  // Unpack the flat channel bus into an indexable array
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      chan[k] = I[k*W +: W];
    end
  end

`ifdef MUX_SCAN_SKIP_EN
  int unsigned idx;
  logic        found;

  // Next unmasked channel above sel, searched circularly; wrap if the search passes N-1
  always_comb begin
    adv_sel  = sel_q;
    adv_wrap = 1'b0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(sel_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && !skip[idx[SW-1:0]]) begin
        found    = 1'b1;
        adv_sel  = idx[SW-1:0];
        adv_wrap = (32'(sel_q) + k) >= N;
      end
    end
  end
`else
  // Next channel in order, modulo N
  always_comb begin
    adv_wrap = (sel_q == SEL_LAST);
    adv_sel  = adv_wrap ? '0 : sel_q + 1'b1;
  end
`endif

  // Select/dwell next-state: load first, then mode change, then scan advance
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    mode_d = mode_t'(mode);
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if ({1'b0, S} < N_EXT) begin
        sel_d = S;
        cnt_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (mode_d != mode_q) begin
      cnt_d = '0;
    end else if (mode_q == MODE_SCAN) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        sel_d  = adv_sel;
        wrap_d = adv_wrap;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State and registered outputs; en=0 freezes everything and clears the pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_MANUAL;
      Y      <= '0;
      ch     <= '0;
      valid  <= 1'b0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else if (en) begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      Y      <= chan[sel_q];
      ch     <= sel_q;
      valid  <= 1'b1;
      wrap   <= wrap_d;
      err    <= err_d;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_n_1.sv
// Directed self-checking bench for mux_scan_n_1 (N=8 and N=6 instances,
// plus a DWELL=1 skip-mask instance when MUX_SCAN_SKIP_EN is defined).
module tb_mux_scan_n_1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] I;
  logic [2:0]  S;
  logic        load, mode, en;
  logic [3:0]  Y;
  logic [2:0]  ch;
  logic        valid, wrap, err;

  logic [23:0] I6;
  logic [2:0]  S6;
  logic        load6, mode6;
  logic [3:0]  Y6;
  logic [2:0]  ch6;
  logic        valid6, wrap6, err6;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int wraps  = 0;

  mux_scan_n_1 #(.N(8), .W(4), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .S(S), .load(load), .mode(mode), .en(en),
`ifdef MUX_SCAN_SKIP_EN
    .skip(8'h00),
`endif
    .Y(Y), .ch(ch), .valid(valid), .wrap(wrap), .err(err)
  );

  mux_scan_n_1 #(.N(6), .W(4), .DWELL(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .I(I6), .S(S6), .load(load6), .mode(mode6), .en(en),
`ifdef MUX_SCAN_SKIP_EN
    .skip(6'h00),
`endif
    .Y(Y6), .ch(ch6), .valid(valid6), .wrap(wrap6), .err(err6)
  );

`ifdef MUX_SCAN_SKIP_EN
  logic [7:0] skip8;
  logic [2:0] Sk;
  logic       loadk, modek;
  logic [3:0] Yk;
  logic [2:0] chk;
  logic       validk, wrapk, errk;
  logic [2:0] exp_chk [5];
  logic       exp_wrk [5];

  mux_scan_n_1 #(.N(8), .W(4), .DWELL(1)) dsk (
    .clk(clk), .rst_n(rst_n), .I(I), .S(Sk), .load(loadk), .mode(modek), .en(en),
    .skip(skip8),
    .Y(Yk), .ch(chk), .valid(validk), .wrap(wrapk), .err(errk)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    I = 32'h7654_3210; S = '0; load = 0; mode = 0; en = 1;
    I6 = 24'h54_3210; S6 = '0; load6 = 0; mode6 = 0;
`ifdef MUX_SCAN_SKIP_EN
    skip8 = 8'b0110_0110; Sk = '0; loadk = 0; modek = 0;
`endif

    // reset held
    tick(); tick();
    check("rst_y", 32'(Y), 0);
    check("rst_ch", 32'(ch), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1;
    tick();
    check("rel_valid", 32'(valid), 1);
    check("rel_y", 32'(Y), 0);
    check("rel_ch", 32'(ch), 0);

    // manual load S=5
    S = 3'd5; load = 1;
    tick();
    load = 0;
    check("load_edge_ch", 32'(ch), 0);
    tick();
    check("load_ch", 32'(ch), 5);
    check("load_y", 32'(Y), 5);
    I[23:20] = 4'hA;
    tick();
    check("live_y", 32'(Y), 32'hA);
    I = 32'h7654_3210;

    // scan full cycle from channel 0
    S = 3'd0; load = 1;
    tick();
    load = 0;
    mode = 1;
    tick();
    check("switch_ch", 32'(ch), 0);
    check("switch_wrap", 32'(wrap), 0);
    for (int t = 1; t <= 32; t++) begin
      tick();
      check("scan_ch", 32'(ch), 32'(((t - 1) / 4) % 8));
      check("scan_y", 32'(Y), 32'(((t - 1) / 4) % 8));
      check("scan_wrap", 32'(wrap), 32'(t == 32));
      if (wrap) wraps++;
    end
    check("scan_wrap_count", 32'(wraps), 1);

    // load mid-dwell, then freeze with en=0
    tick(); tick();
    check("mid_ch", 32'(ch), 0);
    S = 3'd3; load = 1;
    tick();
    load = 0;
    tick();
    check("ld3_ch", 32'(ch), 3);
    en = 0;
    I[15:12] = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("frz_ch", 32'(ch), 3);
      check("frz_y", 32'(Y), 3);
      check("frz_wrap", 32'(wrap), 0);
    end
    I = 32'h7654_3210;
    en = 1;
    tick(); tick(); tick();
    check("dwell_end_ch", 32'(ch), 3);
    tick();
    check("dwell_adv_ch", 32'(ch), 4);
    check("dwell_adv_y", 32'(Y), 4);

    // asynchronous reset mid-scan, restart from channel 0
    #2 rst_n = 0;
    #1;
    check("arst_ch", 32'(ch), 0);
    check("arst_y", 32'(Y), 0);
    check("arst_valid", 32'(valid), 0);
    tick();
    rst_n = 1;
    tick();
    check("rescan_valid", 32'(valid), 1);
    check("rescan_ch0", 32'(ch), 0);
    tick(); tick(); tick(); tick();
    check("rescan_ch_e5", 32'(ch), 0);
    tick();
    check("rescan_ch_e6", 32'(ch), 1);

    // back to manual: sel holds; then scan again with a full dwell
    mode = 0;
    tick();
    repeat (5) tick();
    check("man_hold_ch", 32'(ch), 1);
    check("man_hold_y", 32'(Y), 1);
    mode = 1;
    tick();
    repeat (4) tick();
    check("resume_ch", 32'(ch), 1);
    tick();
    check("resume_adv_ch", 32'(ch), 2);
    check("no_err", 32'(err), 0);

    // N=6 instance: invalid load and modulo-6 wrap
    S6 = 3'd5; load6 = 1;
    tick();
    load6 = 0;
    tick();
    check("n6_ld_ch", 32'(ch6), 5);
    check("n6_ld_y", 32'(Y6), 5);
    S6 = 3'd7; load6 = 1;
    tick();
    check("n6_err", 32'(err6), 1);
    check("n6_err_ch", 32'(ch6), 5);
    load6 = 0;
    tick();
    check("n6_err_clr", 32'(err6), 0);
    check("n6_hold_ch", 32'(ch6), 5);
    mode6 = 1;
    tick();
    tick();
    check("n6_pre_wrap", 32'(wrap6), 0);
    tick();
    check("n6_wrap", 32'(wrap6), 1);
    check("n6_wrap_ch", 32'(ch6), 5);
    tick();
    check("n6_after_ch", 32'(ch6), 0);
    check("n6_after_wrap", 32'(wrap6), 0);
    check("n6_after_y", 32'(Y6), 0);

`ifdef MUX_SCAN_SKIP_EN
    exp_chk = '{3'd0, 3'd3, 3'd4, 3'd7, 3'd0};
    exp_wrk = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    modek = 1;
    tick();
    check("sk_switch_ch", 32'(chk), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sk_ch", 32'(chk), 32'(exp_chk[k]));
      check("sk_wrap", 32'(wrapk), 32'(exp_wrk[k]));
    end
    skip8 = 8'hFF;
    tick(); tick();
    check("sk_all_ch", 32'(chk), 3);
    check("sk_all_wrap", 32'(wrapk), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
